// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: ALU op codes, flag bit indices and helpers shared by the shift sequencer.
package shift_seq_pkg;
  localparam logic [3:0] OP_ROL = 4'h8;
  localparam logic [3:0] OP_ROR = 4'h9;
  localparam logic [3:0] OP_RCL = 4'hA;
  localparam logic [3:0] OP_RCR = 4'hB;
  localparam logic [3:0] OP_SHL = 4'hC;
  localparam logic [3:0] OP_SHR = 4'hD;
  localparam logic [3:0] OP_SAL = 4'hE;
  localparam logic [3:0] OP_SAR = 4'hF;
  localparam int CF = 0;
  localparam int PF = 2;
  localparam int AF = 4;
  localparam int ZF = 6;
  localparam int SF = 7;
  localparam int OF = 11;
  function automatic logic msb_of(input logic [15:0] v, input logic b16);
    return b16 ? v[15] : v[7];
  endfunction
endpackage

// File: rtl/shift_seq_if.sv
// shift_seq_if: request/result handshake plus the per-step ALU bus of the shift sequencer.
interface shift_seq_if;
  logic        start;
  logic [3:0]  op;
  logic        bit16;
  logic [15:0] operand;
  logic [4:0]  count;
  logic [11:0] flags_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [11:0] flags_out;
  logic [3:0]  alu_op;
  logic [15:0] alu_op1;
  logic        alu_bit16;
  logic [11:0] alu_flags;
  logic [15:0] alu_value;
  modport master (
    output start, op, bit16, operand, count, flags_in, alu_value,
    input  busy, done, result, flags_out, alu_op, alu_op1, alu_bit16, alu_flags
  );
  modport slave (
    input  start, op, bit16, operand, count, flags_in, alu_value,
    output busy, done, result, flags_out, alu_op, alu_op1, alu_bit16, alu_flags
  );
endinterface

// File: rtl/shift_seq.sv
// shift_seq: iterates a multi-bit shift/rotate as single-bit ALU steps, one per cycle,
// tracking CF/OF/SF/ZF/PF between steps.
module shift_seq
  import shift_seq_pkg::*;
(
  input logic        clock,
  input logic        reset_n,
  shift_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t      state;
  logic [3:0]  op_r;
  logic        b16_r;
  logic [15:0] val;
  logic [11:0] flg;
  logic [4:0]  rem;
  logic        busy_r, done_r;
  logic [15:0] result_r;
  logic [11:0] flags_r;
  logic [15:0] nv;
  logic        msb_old, nmsb, nmsb1, left, arith, cf_new, of_new;
  logic [11:0] flg_new;
  assign nv = bus.alu_value;
  always_comb begin
    msb_old = msb_of(val, b16_r);
    nmsb    = msb_of(nv, b16_r);
    nmsb1   = b16_r ? nv[14] : nv[6];
    left    = op_r == OP_ROL || op_r == OP_RCL || op_r == OP_SHL || op_r == OP_SAL;
    arith   = op_r >= OP_SHL;
    cf_new  = left ? msb_old : val[0];
    of_new  = (op_r == OP_SHR) ? msb_old :
              (op_r == OP_SAR) ? 1'b0 :
              (op_r == OP_ROR || op_r == OP_RCR) ? nmsb ^ nmsb1 : nmsb ^ cf_new;
    flg_new     = flg;
    flg_new[1]  = 1'b1;
    flg_new[CF] = cf_new;
    flg_new[OF] = of_new;
    flg_new[SF] = arith ? nmsb : flg[SF];
    flg_new[ZF] = arith ? (b16_r ? nv == 16'h0 : nv[7:0] == 8'h0) : flg[ZF];
    flg_new[PF] = arith ? ~^nv[7:0] : flg[PF];
  end
  assign bus.alu_op    = state == SHIFT ? op_r : 4'h0;
  assign bus.alu_op1   = state == SHIFT ? val : 16'h0;
  assign bus.alu_bit16 = state == SHIFT ? b16_r : 1'b0;
  assign bus.alu_flags = state == SHIFT ? flg : 12'h0;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.flags_out = flags_r;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op_r     <= '0;
      b16_r    <= 1'b0;
      val      <= '0;
      flg      <= '0;
      rem      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      flags_r  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_r   <= bus.op;
          b16_r  <= bus.bit16;
          val    <= bus.operand;
          flg    <= bus.flags_in;
          rem    <= bus.count;
          busy_r <= 1'b1;
          // a zero count finishes immediately with the operand and flags untouched
          if (bus.count == 5'd0) begin
            state    <= FIN;
            done_r   <= 1'b1;
            result_r <= bus.bit16 ? bus.operand : {8'h0, bus.operand[7:0]};
            flags_r  <= bus.flags_in;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          val <= nv;
          flg <= flg_new;
          rem <= rem - 5'd1;
          if (rem == 5'd1) begin
            state    <= FIN;
            done_r   <= 1'b1;
            result_r <= b16_r ? nv : {8'h0, nv[7:0]};
            flags_r  <= flg_new;
          end
        end
        FIN: begin
          state  <= IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed checks of shift_seq against a behavioural one-bit ALU.
module tb_shift_seq;
  import shift_seq_pkg::*;
  logic clock = 1'b0;
  logic reset_n;
  int checks = 0;
  int errors = 0;
  shift_seq_if bus();
  shift_seq dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  // stand-in for the downstream ALU: one-bit shift of alu_op1, carry-in from alu_flags[0]
  always_comb begin
    logic [15:0] v;
    logic        cf;
    v  = bus.alu_op1;
    cf = bus.alu_flags[0];
    bus.alu_value = 16'h0;
    case (bus.alu_op)
      OP_ROL: bus.alu_value = bus.alu_bit16 ? {v[14:0], v[15]} : {8'h0, v[6:0], v[7]};
      OP_ROR: bus.alu_value = bus.alu_bit16 ? {v[0], v[15:1]} : {8'h0, v[0], v[7:1]};
      OP_RCL: bus.alu_value = bus.alu_bit16 ? {v[14:0], cf} : {8'h0, v[6:0], cf};
      OP_RCR: bus.alu_value = bus.alu_bit16 ? {cf, v[15:1]} : {8'h0, cf, v[7:1]};
      OP_SHL, OP_SAL: bus.alu_value = bus.alu_bit16 ? {v[14:0], 1'b0} : {8'h0, v[6:0], 1'b0};
      OP_SHR: bus.alu_value = bus.alu_bit16 ? {1'b0, v[15:1]} : {8'h0, 1'b0, v[7:1]};
      OP_SAR: bus.alu_value = bus.alu_bit16 ? {v[15], v[15:1]} : {8'h0, v[7], v[7:1]};
      default: bus.alu_value = 16'h0;
    endcase
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [3:0] o, input logic b, input logic [15:0] v,
                        input logic [4:0] c, input logic [11:0] f);
    @(negedge clock);
    bus.op = o; bus.bit16 = b; bus.operand = v; bus.count = c; bus.flags_in = f;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask
  task automatic finish_chk(input string tag, input int n0, input int lat,
                            input logic [15:0] er, input logic [11:0] ef);
    int n;
    n = n0;
    while (!bus.done && n < 64) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " result"}, bus.result, er);
    chk({tag, " flags"}, bus.flags_out, ef);
    chk({tag, " busy at done"}, bus.busy, 1'b1);
    @(negedge clock);
    chk({tag, " done pulse"}, bus.done, 1'b0);
    chk({tag, " busy after"}, bus.busy, 1'b0);
    chk({tag, " result held"}, bus.result, er);
  endtask
  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0; bus.op = 4'h0; bus.bit16 = 1'b0;
    bus.operand = 16'h0; bus.count = 5'd0; bus.flags_in = 12'h0;
    #1;
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst result", bus.result, 16'h0);
    chk("rst flags", bus.flags_out, 12'h0);
    chk("rst alu_op1", bus.alu_op1, 16'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    launch(OP_SHL, 1'b0, 16'h0081, 5'd1, 12'h000);
    finish_chk("shl8", 1, 2, 16'h0002, 12'h803);
    launch(OP_SHR, 1'b1, 16'h8000, 5'd15, 12'h000);
    finish_chk("shr16", 1, 16, 16'h0001, 12'h002);
    launch(OP_RCL, 1'b0, 16'h0080, 5'd9, 12'h001);
    finish_chk("rcl9", 1, 10, 16'h0080, 12'h003);
    launch(OP_ROL, 1'b1, 16'h1234, 5'd0, 12'hF02);
    finish_chk("cnt0", 1, 1, 16'h1234, 12'hF02);
    launch(OP_ROR, 1'b0, 16'h0001, 5'd1, 12'h4D4);
    finish_chk("ror8", 1, 2, 16'h0080, 12'hCD7);
    launch(OP_SAR, 1'b1, 16'h8001, 5'd2, 12'h000);
    finish_chk("sar16", 1, 3, 16'hE000, 12'h086);
    launch(OP_SAL, 1'b0, 16'h0080, 5'd1, 12'h000);
    finish_chk("sal_zero", 1, 2, 16'h0000, 12'h847);
    launch(OP_RCR, 1'b1, 16'h0001, 5'd17, 12'h000);
    finish_chk("rcr17", 1, 18, 16'h0001, 12'h002);
    launch(OP_ROL, 1'b0, 16'h0001, 5'd31, 12'h000);
    finish_chk("rol31", 1, 32, 16'h0080, 12'h802);
    chk("idle alu_op", bus.alu_op, 4'h0);
    chk("idle alu_op1", bus.alu_op1, 16'h0);
    // second request while busy must be dropped, not queued
    launch(OP_ROL, 1'b1, 16'h00F0, 5'd4, 12'h000);
    bus.op = OP_SHR; bus.operand = 16'hFFFF; bus.count = 5'd0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    finish_chk("busy_start", 2, 5, 16'h0F00, 12'h002);
    repeat (3) @(negedge clock);
    chk("no queued done", bus.done, 1'b0);
    chk("no queued result", bus.result, 16'h0F00);
    // reset in the middle of a long operation
    launch(OP_SAR, 1'b1, 16'h8000, 5'd20, 12'h000);
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst busy", bus.busy, 1'b0);
    chk("midrst done", bus.done, 1'b0);
    chk("midrst result", bus.result, 16'h0);
    chk("midrst flags", bus.flags_out, 12'h0);
    chk("midrst alu_op1", bus.alu_op1, 16'h0);
    @(negedge clock);
    reset_n = 1'b1;
    launch(OP_SHL, 1'b1, 16'h0001, 5'd3, 12'h000);
    chk("step alu_op", bus.alu_op, OP_SHL);
    chk("step alu_op1", bus.alu_op1, 16'h0001);
    chk("step alu_bit16", bus.alu_bit16, 1'b1);
    finish_chk("post_rst", 1, 4, 16'h0008, 12'h002);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clock  in  1  system clock, all state on rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  single-cycle request; sampled only in IDLE.
REQ-005 op  in  4  shift/rotate ALU code 8..F (ROL, ROR, RCL, RCR, SHL, SHR, SHL alias, SAR).
REQ-006 bit16  in  1  1 = 16-bit operand, 0 = 8-bit (low byte).
REQ-007 operand  in  16  value to shift.
REQ-008 count  in  5  shift count (CL already masked to 5 bits).
REQ-009 flags_in  in  12  flags before the instruction.
REQ-010 alu_op / alu_op1 / alu_bit16 / alu_flags  out  4/16/1/12  drive the downstream ALU each step.
REQ-011 alu_value  in  16  one-bit-shift result returned combinationally by the ALU.
REQ-012 busy  out  1  high from the cycle after an accepted start until done.
REQ-013 done  out  1  one-cycle pulse; result and flags_out valid in the same cycle and held until the next start.
REQ-014 result  out  16  final operand, with the upper byte zero in 8-bit mode.
REQ-015 flags_out  out  12  final flags.

Function
REQ-016 The state machine SHALL have three states: IDLE, SHIFT and FIN.
- IDLE + start, count != 0 -> SHIFT.
- IDLE + start, count == 0 -> FIN.
- SHIFT with remaining == 1 -> FIN.
- FIN -> IDLE, with done asserted during FIN.
REQ-017 On accept, the block SHALL latch op, bit16, operand, flags_in, and remaining = count.
REQ-018 In SHIFT, each cycle SHALL present alu_op1 = current value, alu_op = op, alu_flags = current flags; on the edge it SHALL:
- load alu_value into the current value;
- decrement remaining.
REQ-019 Carry SHALL be captured each step from the pre-shift value:
- left ops: CF = old MSB (bit 7 or bit 15);
- right ops: CF = old LSB.
REQ-020 Because RCL/RCR take CF through alu_flags[0], CF SHALL be updated in the same edge as the value.
REQ-021 OF SHALL be evaluated on every step, and the last step's value is final:
- ROL/RCL/SHL: OF = new MSB ^ CF;
- ROR/RCR: OF = new MSB ^ new MSB-1;
- SHR: OF = old MSB;
- SAR: OF = 0.
REQ-022 SF, ZF and PF (PF over the low byte, even parity = 1) SHALL be updated only for codes C..F; rotates preserve them.
REQ-023 AF, DF, IF and TF SHALL be preserved; bit 1 SHALL be forced to 1.
REQ-024 For count == 0, result SHALL equal operand and flags_out SHALL equal flags_in.
REQ-025 Latency SHALL be count+1 cycles from the start edge to done, with count 0 giving 1 cycle and count 31 giving 32.
REQ-026 Counts larger than the operand width SHALL iterate literally, so RCL/RCR behave as 9-bit or 17-bit rotates without modulo logic.
REQ-027 start while busy or during FIN SHALL be ignored, with no queueing.
REQ-028 In IDLE, the alu_* outputs SHALL be zero.

Reset
REQ-029 Reset assertion SHALL immediately force the following, including mid-operation, with no done pulse:
- state = IDLE;
- busy = 0, done = 0;
- result = 0, flags_out = 0;
- internal registers = 0.
REQ-030 The first start after reset release SHALL be accepted normally.

Structure
REQ-031 The ALU op codes and flag bit indices (CF=0, PF=2, AF=4, ZF=6, SF=7, OF=11) SHALL come from the shared localparam include; state encodings stay local.
REQ-032 The block SHALL not instantiate the ALU; the parent connects the existing alu, so there is no sub-module.

Verification
REQ-033 SHL, 8-bit, 0x81, count 1, CF 0 -> done 2 cycles after start; result 0x02; CF=1, OF=1, ZF=0, SF=0, PF=0.
REQ-034 SHR, 16-bit, 0x8000, count 15 -> done after 16 cycles; result 0x0001; CF=0, ZF=0, OF=0.
REQ-035 RCL, 8-bit, 0x80, count 9, CF=1 -> result 0x80, CF=1 (full 9-bit rotation).
REQ-036 ROL, 16-bit, 0x1234, count 0, flags 0x0F02 -> done after 1 cycle; result 0x1234; flags_out 0x0F02.
REQ-037 SAR, count 20, reset_n low at step 5 -> busy=0, result=0, no done; a subsequent SHL 0x0001 count 3 -> 0x0008.
REQ-038 A second start pulsed while busy -> ignored, and the first result is unchanged.
